// File: rtl/hamming_pkg.sv
// Shared constants, state encoding and stage helpers for the Hamming
// datapath sequencer.
package hamming_pkg;

  localparam int DATA_W  = 4;
  localparam int CODE_W  = 7;
  // The syndrome addresses one of CODE_W bit positions, 0 meaning "no error".
  localparam int POS_W   = CODE_W - DATA_W;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    GEN   = 3'd1,
    ENC   = 3'd2,
    ERR   = 3'd3,
    CORR  = 3'd4,
    CHECK = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam int NUM_STAGES = 4;
  localparam int STG_GEN    = 0;
  localparam int STG_ENC    = 1;
  localparam int STG_ERR    = 2;
  localparam int STG_CORR   = 3;

  function automatic logic is_stage(state_t s);
    return (s == GEN) || (s == ENC) || (s == ERR) || (s == CORR);
  endfunction

  function automatic state_t stage_state(int idx);
    case (idx)
      STG_GEN:  return GEN;
      STG_ENC:  return ENC;
      STG_ERR:  return ERR;
      STG_CORR: return CORR;
      default:  return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/hamming_sequencer_if.sv
// Stage-enable / position / syndrome bundle between the sequencer (master)
// and the Hamming datapath stages (slave).
interface hamming_sequencer_if #(
  parameter int POS_W = hamming_pkg::POS_W
) ();

  logic             en_gen;
  logic             en_enc;
  logic             en_err;
  logic             en_corr;
  logic [POS_W-1:0] pos_out;
  logic [POS_W-1:0] syndrome;

  modport master (
    output en_gen, en_enc, en_err, en_corr, pos_out,
    input  syndrome
  );

  modport slave (
    input  en_gen, en_enc, en_err, en_corr, pos_out,
    output syndrome
  );

endinterface

// File: rtl/stage_timer.sv
// Loadable down-counter timing how long each stage enable stays high;
// expire flags the final cycle of the current hold.
module stage_timer #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] hold_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= hold_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign expire = (cnt_reg == '0);

endmodule

// File: rtl/hamming_sequencer.sv
// Batch sequencer for the Hamming datapath: steps GEN->ENC->ERR->CORR->CHECK
// per word, one stage enable at a time, and scores syndromes against pos_out.
module hamming_sequencer
  import hamming_pkg::*;
#(
  parameter int NUM_WORDS  = 8,
  parameter int STAGE_HOLD = 1,
  parameter int POS_W      = hamming_pkg::POS_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               inject_en,
  input  logic [POS_W-1:0]   inject_pos,
  hamming_sequencer_if.master dp,
  output logic               busy,
  output logic               done,
  output logic [3:0]         word_cnt,
  output logic [3:0]         fail_cnt,
  output logic [STATE_W-1:0] state_o
);

  localparam int              CNT_W       = $clog2(STAGE_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(STAGE_HOLD - 1);
  localparam logic [3:0]      LAST_WORD   = 4'(NUM_WORDS);

  state_t                  state_reg;
  state_t                  state_next;
  logic [POS_W-1:0]        pos_reg;
  logic [3:0]              word_cnt_reg;
  logic [3:0]              fail_cnt_reg;
  logic [3:0]              word_cnt_inc;
  logic                    timer_load;
  logic                    timer_expire;
  logic                    accept;
  logic                    score;
  logic [NUM_STAGES-1:0]   en_vec;

  assign word_cnt_inc = word_cnt_reg + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)        state_next = GEN;
      GEN:     if (timer_expire) state_next = ENC;
      ENC:     if (timer_expire) state_next = ERR;
      ERR:     if (timer_expire) state_next = CORR;
      CORR:    if (timer_expire) state_next = CHECK;
      CHECK:   state_next = (word_cnt_inc == LAST_WORD) ? DONE : GEN;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // abort overrides every transition, including start in IDLE
    if (abort) begin
      state_next = IDLE;
    end
  end

  // Reload the hold counter on every entry into a stage state.
  assign timer_load = is_stage(state_next) && (state_next != state_reg);

  stage_timer #(
    .CNT_W (CNT_W)
  ) u_stage_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .hold_val (HOLD_RELOAD),
    .expire   (timer_expire)
  );

  assign accept = (state_reg == IDLE)  && start && !abort;
  assign score  = (state_reg == CHECK) && !abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_reg      <= '0;
      word_cnt_reg <= '0;
      fail_cnt_reg <= '0;
    end else if (accept) begin
      pos_reg      <= inject_en ? inject_pos : '0;
      word_cnt_reg <= '0;
      fail_cnt_reg <= '0;
    end else if (score) begin
      // syndrome was registered by the corrector on the last CORR edge
      word_cnt_reg <= word_cnt_inc;
      if (dp.syndrome != pos_reg) begin
        fail_cnt_reg <= fail_cnt_reg + 4'd1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_en
    assign en_vec[gi] = (state_reg == stage_state(gi));
  end

  assign dp.en_gen  = en_vec[STG_GEN];
  assign dp.en_enc  = en_vec[STG_ENC];
  assign dp.en_err  = en_vec[STG_ERR];
  assign dp.en_corr = en_vec[STG_CORR];
  assign dp.pos_out = pos_reg;

  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign word_cnt = word_cnt_reg;
  assign fail_cnt = fail_cnt_reg;
  assign state_o  = state_reg;

endmodule

// File: tb/tb_hamming_sequencer.sv
// Scoreboard bench for hamming_sequencer: per-cycle expected records are queued
// when a batch is launched and popped against the observed outputs.
module tb_hamming_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start      [2];
  logic       abort      [2];
  logic       inject_en  [2];
  logic [2:0] inject_pos [2];
  logic [2:0] syn_v      [2];
  logic [2:0] syn_plan   [16];

  logic       busy0, busy1, done0, done1;
  logic [3:0] word_cnt0, word_cnt1, fail_cnt0, fail_cnt1;
  logic [2:0] state_o0, state_o1;

  hamming_sequencer_if if0 ();
  hamming_sequencer_if if1 ();
  assign if0.syndrome = syn_v[0];
  assign if1.syndrome = syn_v[1];

  hamming_sequencer #(.NUM_WORDS(8), .STAGE_HOLD(1)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
    .inject_en(inject_en[0]), .inject_pos(inject_pos[0]), .dp(if0),
    .busy(busy0), .done(done0), .word_cnt(word_cnt0), .fail_cnt(fail_cnt0),
    .state_o(state_o0)
  );

  hamming_sequencer #(.NUM_WORDS(2), .STAGE_HOLD(3)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
    .inject_en(inject_en[1]), .inject_pos(inject_pos[1]), .dp(if1),
    .busy(busy1), .done(done1), .word_cnt(word_cnt1), .fail_cnt(fail_cnt1),
    .state_o(state_o1)
  );

  int          sel = 0;
  logic [3:0]  en_o;
  logic [19:0] obs;

  // Record layout: state[19:17] busy[16] done[15] en[14:11] pos[10:8] wc[7:4] fc[3:0]
  always_comb begin
    en_o = (sel == 1) ? {if1.en_corr, if1.en_err, if1.en_enc, if1.en_gen}
                      : {if0.en_corr, if0.en_err, if0.en_enc, if0.en_gen};
    obs  = (sel == 1) ? {state_o1, busy1, done1, en_o, if1.pos_out, word_cnt1, fail_cnt1}
                      : {state_o0, busy0, done0, en_o, if0.pos_out, word_cnt0, fail_cnt0};
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  int          batch_no = 0;
  logic [19:0] exp_q[$];
  logic [19:0] last_exp;

  task automatic check_val(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%05h, expected 0x%05h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] rec(input logic [2:0] st, input logic bsy, input logic dn,
                                      input logic [3:0] en, input logic [2:0] pos,
                                      input logic [3:0] wc, input logic [3:0] fc);
    return {st, bsy, dn, en, pos, wc, fc};
  endfunction

  task automatic run_batch(input int s, input int nw, input int hold, input logic ien,
                           input logic [2:0] ipos, input int abort_at,
                           input int restart_at, input int poschg_at);
    logic [19:0] e;
    logic [2:0]  pos_e;
    logic [3:0]  wc;
    logic [3:0]  fc;
    int          i;
    pos_e = ien ? ipos : 3'd0;
    wc = 4'd0;
    fc = 4'd0;
    for (int w = 0; w < nw; w++) begin
      for (int st = 0; st < 4; st++) begin
        for (int h = 0; h < hold; h++) begin
          exp_q.push_back(rec(3'(st + 1), 1'b1, 1'b0, 4'(1 << st), pos_e, wc, fc));
        end
      end
      exp_q.push_back(rec(3'd5, 1'b1, 1'b0, 4'd0, pos_e, wc, fc));
      wc = wc + 4'd1;
      if (syn_plan[w] != pos_e) fc = fc + 4'd1;
    end
    exp_q.push_back(rec(3'd6, 1'b1, 1'b1, 4'd0, pos_e, wc, fc));
    exp_q.push_back(rec(3'd0, 1'b0, 1'b0, 4'd0, pos_e, wc, fc));
    if (abort_at >= 0) begin
      while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
      e = exp_q[$];
      exp_q.push_back({9'd0, e[10:0]});
    end
    last_exp = exp_q[$];

    sel = s;
    @(negedge clk);
    inject_en[s]  = ien;
    inject_pos[s] = ipos;
    start[s]      = 1'b1;
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start[s] = 1'b0;
      abort[s] = 1'b0;
      e = exp_q.pop_front();
      check_val($sformatf("b%0d_cyc%0d", batch_no, i), obs, e);
      check_val($sformatf("b%0d_onehot%0d", batch_no, i), 20'($countones(en_o) <= 1), 20'd1);
      // act as the corrector: present this word's syndrome from CORR onward
      if (en_o[3]) syn_v[s] = syn_plan[i / (4 * hold + 1)];
      if (i == abort_at)   abort[s] = 1'b1;
      if (i == restart_at) start[s] = 1'b1;
      if (i == poschg_at)  begin inject_en[s] = 1'b1; inject_pos[s] = ~ipos; end
      i++;
    end
    $display("[TB] batch %0d inst %0d: words=%0d hold=%0d word_cnt=%0d fail_cnt=%0d pos=%0d",
             batch_no, s, nw, hold, obs[7:4], obs[3:0], obs[10:8]);
    batch_no++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    for (int s = 0; s < 2; s++) begin
      start[s] = 1'b0; abort[s] = 1'b0; inject_en[s] = 1'b0;
      inject_pos[s] = 3'd0; syn_v[s] = 3'd0;
    end
    for (int w = 0; w < 16; w++) syn_plan[w] = 3'd0;

    repeat (2) @(negedge clk);
    sel = 0; #1 check_val("reset_inst0", obs, 20'd0);
    sel = 1; #1 check_val("reset_inst1", obs, 20'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // plain batch; inject_pos ignored because inject_en=0
    run_batch(0, 8, 1, 1'b0, 3'd4, -1, -1, -1);

    // injected position 5, last word reports a wrong syndrome
    for (int w = 0; w < 8; w++) syn_plan[w] = (w == 7) ? 3'd3 : 3'd5;
    run_batch(0, 8, 1, 1'b1, 3'd5, -1, -1, -1);

    // long hold, short batch on the second instance
    for (int w = 0; w < 16; w++) syn_plan[w] = 3'd0;
    run_batch(1, 2, 3, 1'b0, 3'd0, -1, -1, -1);

    // start during GEN of word 1 and inject_pos change mid-batch are ignored
    for (int w = 0; w < 16; w++) syn_plan[w] = 3'd2;
    run_batch(0, 8, 1, 1'b1, 3'd2, -1, 5, 6);

    // start with abort in IDLE: nothing happens, counters hold
    sel = 0;
    @(negedge clk);
    start[0] = 1'b1; abort[0] = 1'b1; inject_en[0] = 1'b1; inject_pos[0] = 3'd7;
    @(negedge clk);
    start[0] = 1'b0; abort[0] = 1'b0;
    check_val("start_abort_idle", obs, {9'd0, last_exp[10:0]});
    @(negedge clk);
    check_val("start_abort_idle2", obs, {9'd0, last_exp[10:0]});

    // abort during ERR of word 3
    for (int w = 0; w < 16; w++) syn_plan[w] = 3'd0;
    run_batch(0, 8, 1, 1'b0, 3'd0, 17, -1, -1);

    // fresh batch after abort starts from cleared counters
    for (int w = 0; w < 16; w++) syn_plan[w] = (w % 2 == 0) ? 3'd1 : 3'd0;
    run_batch(0, 8, 1, 1'b1, 3'd1, -1, -1, -1);

    // asynchronous reset between edges while in CORR
    sel = 0;
    @(negedge clk);
    inject_en[0] = 1'b1; inject_pos[0] = 3'd6; start[0] = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (en_o[3]) found = 1;
    end
    check_val("reach_corr", 20'(found), 20'd1);
    #2 rst = 1'b0;
    #1 check_val("async_reset", obs, 20'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("idle_after_reset", obs, 20'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_sequencer.md
Name: hamming_sequencer

Overview:
- Handshake-driven sequencer for the Hamming datapath: data generator -> (7,4) encoder -> error injector -> corrector.
- Replaces the free-running ring counter as the source of stage enables.
- Runs a batch of NUM_WORDS words on a start pulse and drives one stage enable at a time.
- Supplies the latched error-injection position to the injector and scores each word by comparing the corrector's syndrome with the injected position.

Parameters:
- NUM_WORDS, 8, words per batch (1..15).
- STAGE_HOLD, 1, cycles each stage enable is held high (1..7).
- POS_W, 3, width of the error position and of the syndrome.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a batch; ignored unless in IDLE.
- abort  in  1  level; forces a return to IDLE.
- inject_en  in  1  enables error injection for the batch; sampled with start.
- inject_pos  in  POS_W  injected bit position (0 = none); sampled with start.
- syndrome  in  POS_W  registered syndrome from the corrector.
- en_gen  out  1  enable for the data generator.
- en_enc  out  1  enable for the encoder.
- en_err  out  1  enable for the error injector.
- en_corr  out  1  enable for the corrector.
- pos_out  out  POS_W  latched injection position, to the injector.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at batch completion.
- word_cnt  out  4  words completed in the current or last batch.
- fail_cnt  out  4  words whose syndrome differed from pos_out.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All enables, busy and done = 0.
  - pos_out, word_cnt and fail_cnt = 0.
- States, with encoding: IDLE=0, GEN=1, ENC=2, ERR=3, CORR=4, CHECK=5, DONE=6. Code 7 is illegal and decodes to IDLE on the next edge.
- IDLE:
  - On start=1 at an edge: latch pos_out = inject_en ? inject_pos : 0, clear word_cnt and fail_cnt, go to GEN.
- GEN, ENC, ERR, CORR:
  - The matching en_* output is high for exactly STAGE_HOLD cycles; all other enables are 0.
  - After STAGE_HOLD cycles, advance to the next state in the order GEN -> ENC -> ERR -> CORR -> CHECK.
  - A hold counter reloads on every state entry.
- Enables are decoded from registered state, so they are glitch-free. At most one enable is high in any cycle.
- CHECK (one cycle, all enables 0):
  - Sample syndrome, which is valid because the corrector registered it on the last CORR edge.
  - If syndrome != pos_out, fail_cnt increments.
  - word_cnt always increments.
  - If the new word_cnt == NUM_WORDS, go to DONE; otherwise go to GEN.
- DONE: done=1 for one cycle, busy still 1, then go to IDLE.
- Latency:
  - One word = 4*STAGE_HOLD+1 cycles.
  - With STAGE_HOLD=1, counting the first GEN cycle as cycle 0, done is high in cycle 5*NUM_WORDS.
- Counters:
  - word_cnt and fail_cnt hold their values in IDLE until the next accepted start.
  - fail_cnt never exceeds word_cnt.
- pos_out is stable for the whole batch; changes to inject_pos mid-batch are ignored.
- abort:
  - From any non-IDLE state, the next edge goes to IDLE with all enables 0 and no done pulse.
  - Counters hold their partial values.
  - abort has priority over start and over the CHECK/DONE transitions.
- start and abort asserted together in IDLE: the design stays in IDLE.
- start while busy: ignored, with no restart and no counter change.
- Reset mid-batch: immediate return to the reset values, regardless of clk.

Decomposition:
- Package hamming_pkg holds:
  - state localparams IDLE..DONE and a 3-bit state width;
  - DATA_W=4, CODE_W=7, POS_W=3;
  - stage-index constants.
- Sub-module stage_timer:
  - Loadable down-counter with width $clog2(STAGE_HOLD+1).
  - Inputs load and hold value; output expire.
  - Instantiated once.

Test Plan:
- Reset, then start with inject_en=0, NUM_WORDS=8, STAGE_HOLD=1, syndrome tied 0 -> en_gen/enc/err/corr each pulse 1 cycle in order 8 times; done at cycle 40 after the first GEN; word_cnt=8; fail_cnt=0.
- start with inject_en=1, inject_pos=5, bench drives syndrome=5 on words 0-6 and 3 on word 7 -> fail_cnt=1, word_cnt=8, pos_out=5 throughout.
- STAGE_HOLD=3, NUM_WORDS=2 -> each enable high for exactly 3 cycles; done at cycle 26; the one-hot check never violated.
- abort asserted during the ERR of word 3 -> IDLE on the next edge, no done, word_cnt=3, busy=0; a new start restarts with cleared counters.
- start pulsed during GEN of word 1, and inject_pos changed mid-batch -> no restart, pos_out unchanged; start and abort together in IDLE -> remains IDLE.
- rst driven low asynchronously mid-CORR (between clock edges) -> all outputs 0 immediately; after release the sequencer idles until start.
